// File: rtl/alu_req_arbiter.sv
// Round-robin front end that lets two requesters share one external combinational ALU.
// One transaction in flight; operands held on the ALU for the whole EXEC+RESP window.
module alu_req_arbiter #(
    parameter int WIDTH      = 64,
    parameter int SHIFT_W    = 5,
    parameter int MUL_CYCLES = 3,
    parameter int NUM_OPS    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [3:0]         req0_opcode,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [SHIFT_W-1:0] req0_shift,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [3:0]         req1_opcode,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [SHIFT_W-1:0] req1_shift,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [WIDTH-1:0]   rsp0_result,
    output logic [3:0]         rsp0_flags,
    output logic               rsp0_err,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [WIDTH-1:0]   rsp1_result,
    output logic [3:0]         rsp1_flags,
    output logic               rsp1_err,
    output logic [3:0]         alu_opcode,
    output logic [WIDTH-1:0]   alu_input1,
    output logic [WIDTH-1:0]   alu_input2,
    output logic [SHIFT_W-1:0] alu_shiftValue,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carryFlag,
    input  logic               alu_zeroFlag,
    input  logic               alu_overFlowFlag,
    input  logic               alu_signFlag,
    output logic [31:0]        op_count
);

    localparam int         CNT_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [3:0] OP_MUL = 4'd4;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               gid_q, gid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [SHIFT_W-1:0] sh_q, sh_d;
    logic [WIDTH-1:0]   res_q [2];
    logic [WIDTH-1:0]   res_d [2];
    logic [3:0]         flg_q [2];
    logic [3:0]         flg_d [2];
    logic [1:0]         err_q, err_d;
    logic [31:0]        op_count_q, op_count_d;

    logic               grant;
    logic [3:0]         req_op;
    logic               illegal;
    logic               rsp_hs;

    // On a tie the requester that was not served last wins.
    assign grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign req0_ready = (state_q == S_IDLE) && !grant && req0_valid;
    assign req1_ready = (state_q == S_IDLE) &&  grant && req1_valid;
    assign req_op     = grant ? req1_opcode : req0_opcode;

    assign rsp0_valid = (state_q == S_RESP) && !gid_q;
    assign rsp1_valid = (state_q == S_RESP) &&  gid_q;
    assign rsp_hs     = (state_q == S_RESP) && (gid_q ? rsp1_ready : rsp0_ready);
    assign illegal    = (op_q >= 4'(NUM_OPS));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gid_d        = gid_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        sh_d         = sh_q;
        res_d        = res_q;
        flg_d        = flg_q;
        err_d        = err_q;
        op_count_d   = op_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    gid_d   = grant;
                    op_d    = req_op;
                    a_d     = grant ? req1_a : req0_a;
                    b_d     = grant ? req1_b : req0_b;
                    sh_d    = grant ? req1_shift : req0_shift;
                    cnt_d   = (req_op == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Illegal opcodes skip any MUL wait and report a zeroed payload.
                if (illegal || cnt_q == '0) begin
                    res_d[gid_q] = illegal ? '0 : alu_result;
                    flg_d[gid_q] = illegal ? 4'b0 :
                                   {alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag};
                    err_d[gid_q] = illegal;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_hs) begin
                    last_grant_d = gid_q;
                    op_count_d   = op_count_q + 32'd1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gid_q        <= 1'b0;
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sh_q         <= '0;
            res_q        <= '{default: '0};
            flg_q        <= '{default: '0};
            err_q        <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gid_q        <= gid_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sh_q         <= sh_d;
            res_q        <= res_d;
            flg_q        <= flg_d;
            err_q        <= err_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_opcode     = op_q;
    assign alu_input1     = a_q;
    assign alu_input2     = b_q;
    assign alu_shiftValue = sh_q;
    assign rsp0_result    = res_q[0];
    assign rsp1_result    = res_q[1];
    assign rsp0_flags     = flg_q[0];
    assign rsp1_flags     = flg_q[1];
    assign rsp0_err       = err_q[0];
    assign rsp1_err       = err_q[1];
    assign op_count       = op_count_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: provides the external ALU (MUL only settles after a hold window)
// and checks responses against an expectation queue filled at each request handshake.
module tb_alu_req_arbiter;

    localparam int W  = 64;
    localparam int SW = 5;
    localparam int MC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 0, req1_valid = 0;
    logic          req0_ready, req1_ready;
    logic [3:0]    req0_opcode = 0, req1_opcode = 0;
    logic [W-1:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [SW-1:0] req0_shift = 0, req1_shift = 0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 0, rsp1_ready = 0;
    logic [W-1:0]  rsp0_result, rsp1_result;
    logic [3:0]    rsp0_flags, rsp1_flags;
    logic          rsp0_err, rsp1_err;
    logic [3:0]    alu_opcode;
    logic [W-1:0]  alu_input1, alu_input2, alu_result;
    logic [SW-1:0] alu_shiftValue;
    logic          alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag;
    logic [31:0]   op_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stab = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         err;
    } exp_t;
    exp_t sb[$];

    alu_req_arbiter #(.WIDTH(W), .SHIFT_W(SW), .MUL_CYCLES(MC), .NUM_OPS(6)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
        .alu_carryFlag(alu_carryFlag), .alu_zeroFlag(alu_zeroFlag),
        .alu_overFlowFlag(alu_overFlowFlag), .alu_signFlag(alu_signFlag),
        .op_count(op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [SW-1:0] sh);
        case (op)
            4'd0:    return (a << sh) | (a >> (W - int'(sh)));
            4'd1:    return (a >> sh) | (a << (W - int'(sh)));
            4'd2:    return (a > b) ? a : b;
            4'd3:    return (a < b) ? a : b;
            4'd4:    return a * b;
            4'd5:    return ~(a ^ b);
            default: return 64'h0BAD_0BAD_0BAD_0BAD;
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] r);
        return {^a, (r == '0), ^b, r[W-1]};
    endfunction

    function automatic exp_t mk_exp(input logic id, input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [SW-1:0] sh);
        exp_t e;
        e.id = id;
        if (op >= 4'd6) begin
            e.res = '0; e.flg = 4'b0; e.err = 1'b1;
        end else begin
            e.res = ref_alu(op, a, b, sh);
            e.flg = ref_flags(a, b, e.res);
            e.err = 1'b0;
        end
        return e;
    endfunction

    // External ALU: MUL output is garbage until operands have been held MC-1 cycles past the handshake.
    always @(posedge clk) begin
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) stab <= 0;
        else if (stab < 15) stab <= stab + 1;
    end
    always_comb begin
        if (alu_opcode == 4'd4 && stab < MC - 1) alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
        else alu_result = ref_alu(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
        {alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag} =
            ref_flags(alu_input1, alu_input2, alu_result);
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rsp0_valid && rsp0_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL sb_rsp0: got unexpected response res=%h, required none", rsp0_result);
                end else begin
                    e = sb.pop_front();
                    if (e.id !== 1'b0 || rsp0_result !== e.res || rsp0_flags !== e.flg || rsp0_err !== e.err) begin
                        errors++;
                        $display("FAIL sb_rsp0: got res=%h flg=%b err=%b, required id=%0d res=%h flg=%b err=%b",
                                 rsp0_result, rsp0_flags, rsp0_err, e.id, e.res, e.flg, e.err);
                    end
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL sb_rsp1: got unexpected response res=%h, required none", rsp1_result);
                end else begin
                    e = sb.pop_front();
                    if (e.id !== 1'b1 || rsp1_result !== e.res || rsp1_flags !== e.flg || rsp1_err !== e.err) begin
                        errors++;
                        $display("FAIL sb_rsp1: got res=%h flg=%b err=%b, required id=%0d res=%h flg=%b err=%b",
                                 rsp1_result, rsp1_flags, rsp1_err, e.id, e.res, e.flg, e.err);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    // Presents one request, waits for its handshake, queues its expectation, then drops valid.
    task automatic issue(input logic id, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [SW-1:0] sh, output int t_hs);
        bit got = 0;
        t_hs = -1;
        @(posedge clk); #1;
        if (!id) begin req0_opcode = op; req0_a = a; req0_b = b; req0_shift = sh; req0_valid = 1; end
        else     begin req1_opcode = op; req1_a = a; req1_b = b; req1_shift = sh; req1_valid = 1; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((!id && req0_ready) || (id && req1_ready)) begin got = 1; t_hs = cyc; end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL issue_req%0d: got no ready, required ready within 40 cycles", id);
        end else sb.push_back(mk_exp(id, op, a, b, sh));
        @(posedge clk); #1;
        if (!id) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic wait_rsp(input logic id, output int at);
        at = -1;
        for (int i = 0; i < 20 && at < 0; i++) begin
            @(negedge clk);
            if ((!id && rsp0_valid) || (id && rsp1_valid)) at = cyc;
        end
    endtask

    task automatic test_reset();
        logic [W*4+SW+3*4+4+32+9:0] outs;
        do_reset();
        @(negedge clk);
        outs = {rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp0_err, rsp1_err,
                rsp0_result, rsp1_result, rsp0_flags, rsp1_flags,
                alu_opcode, alu_input1, alu_input2, alu_shiftValue, op_count};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h, required all zero", outs); end
        checks++;
        if (op_count !== 32'd0) begin errors++; $display("FAIL reset_op_count: got %0d, required 0", op_count); end
    endtask

    task automatic test_xnor();
        int t, at;
        rsp0_ready = 1;
        issue(0, 4'd5, 64'h0, 64'h0, 5'd0, t);
        wait_rsp(0, at);
        checks++;
        if (at - t != 2 || at < 0) begin errors++; $display("FAIL xnor_latency: got %0d, required 2", at - t); end
        checks++;
        if (rsp0_result !== 64'hFFFF_FFFF_FFFF_FFFF || rsp0_flags[2] !== 1'b0 || rsp0_flags[0] !== 1'b1) begin
            errors++; $display("FAIL xnor_result: got res=%h flg=%b, required all-ones zero=0 sign=1", rsp0_result, rsp0_flags);
        end
    endtask

    task automatic test_rol();
        int t, at = -1;
        bit bad0 = 0;
        rsp1_ready = 1;
        issue(1, 4'd0, 64'h8000_0000_0000_0001, 64'h0, 5'd1, t);
        for (int i = 0; i < 20 && at < 0; i++) begin
            @(negedge clk);
            if (rsp0_valid) bad0 = 1;
            if (rsp1_valid) at = cyc;
        end
        checks++;
        if (at < 0 || rsp1_result !== 64'h3) begin
            errors++; $display("FAIL rol_result: got %h, required 0000000000000003", rsp1_result);
        end
        checks++;
        if (bad0) begin errors++; $display("FAIL rol_rsp0_quiet: got rsp0_valid=1, required 0"); end
    endtask

    task automatic test_mul();
        int t, at = -1;
        bit moved = 0;
        rsp0_ready = 1;
        issue(0, 4'd4, 64'd3, 64'd5, 5'd7, t);
        for (int i = 0; i < 20 && at < 0; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            if ({alu_opcode, alu_input1, alu_input2, alu_shiftValue} !== {4'd4, 64'd3, 64'd5, 5'd7}) moved = 1;
            if (rsp0_valid) at = cyc;
        end
        checks++;
        if (at < 0 || at - t != MC + 1) begin errors++; $display("FAIL mul_latency: got %0d, required %0d", at - t, MC + 1); end
        checks++;
        if (rsp0_result !== 64'd15) begin errors++; $display("FAIL mul_result: got %0d, required 15", rsp0_result); end
        checks++;
        if (moved) begin errors++; $display("FAIL mul_alu_hold: got alu inputs changing, required held"); end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int hs[$];
        logic [3:0] ops0 [3];
        logic [3:0] ops1 [3];
        int n0 = 0, n1 = 0;
        bit up0, up1, gap_bad = 0, ord_bad = 0;
        ops0 = '{4'd5, 4'd2, 4'd0};
        ops1 = '{4'd3, 4'd1, 4'd5};
        do_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        req0_opcode = ops0[0]; req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; req0_shift = 5'd3;
        req1_opcode = ops1[0]; req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_shift = 5'd9;
        req0_valid = 1; req1_valid = 1;
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            up0 = 0; up1 = 0;
            @(negedge clk);
            if (req0_ready) begin
                grants.push_back(0); hs.push_back(cyc); up0 = 1;
                sb.push_back(mk_exp(0, req0_opcode, req0_a, req0_b, req0_shift));
            end
            if (req1_ready) begin
                grants.push_back(1); hs.push_back(cyc); up1 = 1;
                sb.push_back(mk_exp(1, req1_opcode, req1_a, req1_b, req1_shift));
            end
            @(posedge clk); #1;
            if (up0) begin n0++; req0_opcode = ops0[n0 % 3]; req0_a = {$urandom, $urandom}; end
            if (up1) begin n1++; req1_opcode = ops1[n1 % 3]; req1_b = {$urandom, $urandom}; end
        end
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < grants.size(); i++) if (grants[i] != (i % 2)) ord_bad = 1;
        for (int i = 1; i < hs.size(); i++) if (hs[i] - hs[i-1] != 3) gap_bad = 1;
        checks++;
        if (grants.size() != 6 || ord_bad) begin
            errors++; $display("FAIL rr_order: got %0d grants (order ok=%0d), required 6 alternating 0,1", grants.size(), !ord_bad);
        end
        checks++;
        if (gap_bad) begin errors++; $display("FAIL rr_throughput: got a handshake gap other than 3, required 3"); end
        checks++;
        if (op_count !== 32'd6) begin errors++; $display("FAIL rr_op_count: got %0d, required 6", op_count); end
    endtask

    task automatic test_illegal_hold();
        int t, at, x, t2;
        bit moved = 0, leaked = 0;
        logic [W+4:0] snap;
        rsp1_ready = 0; rsp0_ready = 1;
        issue(1, 4'd9, 64'h1, 64'h2, 5'd0, t);
        wait_rsp(1, at);
        checks++;
        if (at < 0 || at - t != 2) begin errors++; $display("FAIL ill_latency: got %0d, required 2", at - t); end
        checks++;
        if (rsp1_err !== 1'b1 || rsp1_result !== '0 || rsp1_flags !== 4'b0) begin
            errors++; $display("FAIL ill_payload: got err=%b res=%h flg=%b, required err=1 res=0 flg=0", rsp1_err, rsp1_result, rsp1_flags);
        end
        snap = {rsp1_err, rsp1_flags, rsp1_result};
        @(posedge clk); #1;
        req0_opcode = 4'd2; req0_a = 64'd40; req0_b = 64'd41; req0_shift = 0; req0_valid = 1;
        repeat (5) begin
            @(negedge clk);
            if (!rsp1_valid || {rsp1_err, rsp1_flags, rsp1_result} !== snap) moved = 1;
            if (req0_ready) leaked = 1;
        end
        checks++;
        if (moved) begin errors++; $display("FAIL ill_hold: got payload/valid change while stalled, required stable"); end
        checks++;
        if (leaked) begin errors++; $display("FAIL busy_holdoff: got req0_ready=1 while busy, required 0"); end
        @(posedge clk); #1;
        rsp1_ready = 1; x = cyc;
        issue(0, 4'd2, 64'd40, 64'd41, 5'd0, t2);
        checks++;
        if (t2 - x != 1) begin errors++; $display("FAIL next_accept: got %0d cycles after release, required 1", t2 - x); end
        wait_rsp(0, at);
        checks++;
        if (at < 0 || rsp0_result !== 64'd41) begin errors++; $display("FAIL max_result: got %0d, required 41", rsp0_result); end
    endtask

    task automatic test_abort();
        int t;
        bit seen = 0;
        logic [W*4+SW+3*4+4+32+9:0] outs;
        rsp0_ready = 1;
        issue(0, 4'd4, 64'd7, 64'd9, 5'd2, t);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        sb.delete();
        @(negedge clk);
        outs = {rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp0_err, rsp1_err,
                rsp0_result, rsp1_result, rsp0_flags, rsp1_flags,
                alu_opcode, alu_input1, alu_input2, alu_shiftValue, op_count};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL abort_outputs: got %h, required all zero", outs); end
        repeat (6) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) seen = 1;
        end
        checks++;
        if (seen || op_count !== 32'd0) begin
            errors++; $display("FAIL abort_no_rsp: got rsp seen=%0d op_count=%0d, required 0 and 0", seen, op_count);
        end
    endtask

    initial begin
        test_reset();
        test_xnor();
        test_rol();
        test_mul();
        test_round_robin();
        test_illegal_hold();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
